multiplier_control: RTL

Control-unit FSM for the 8-bit signed shift-add multiplier. It turns the active-low `Run` and `ClearA_LoadB` buttons into per-cycle datapath strobes: load B, clear A/X, add, subtract and shift. It sits beside the A/B/X register file and the 9-bit adder inside `multiplier`, replacing ad-hoc control logic. Each button press produces exactly one multiplication of fixed latency.

---
 rtl/multiplier_control.sv | 107 ++++++++++
 1 files changed

// File: rtl/multiplier_control.sv
// Control FSM for the 8-bit signed shift-add multiplier: turns the active-low
// Run / ClearA_LoadB buttons into one-hot datapath strobes with fixed latency.
module multiplier_control #(
  parameter int N = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       ClearA_LoadB,
  input  logic       M,
  output logic       Ld_B,
  output logic       Clr_AX,
  output logic       Add,
  output logic       Sub,
  output logic       Shift,
  output logic       Busy,
  output logic       Done,
  output logic [2:0] dbg_state
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [KW-1:0] k;
  logic          load_armed;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_nxt;
      if (state == START)
        k <= '0;
      else if (state == SHIFT && k != K_LAST)
        k <= k + 1'b1;
    end
  end

  // A held load button fires once; it must go high again before the next load.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      load_armed <= 1'b1;
    else if (ClearA_LoadB)
      load_armed <= 1'b1;
    else if (state == IDLE && state_nxt == LOAD)
      load_armed <= 1'b0;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!ClearA_LoadB && load_armed) state_nxt = LOAD;
        else if (!Run)                   state_nxt = START;
      end
      LOAD:    state_nxt = IDLE;
      START:   state_nxt = ADD;
      ADD:     state_nxt = SHIFT;
      SHIFT:   state_nxt = (k == K_LAST) ? DONE : ADD;
      DONE:    if (Run) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The last iteration weighs the multiplier sign bit, hence Sub instead of Add.
  always_comb begin
    Ld_B   = 1'b0;
    Clr_AX = 1'b0;
    Add    = 1'b0;
    Sub    = 1'b0;
    Shift  = 1'b0;
    Busy   = 1'b0;
    Done   = 1'b0;
    unique case (state)
      LOAD:  Ld_B = 1'b1;
      START: begin
        Clr_AX = 1'b1;
        Busy   = 1'b1;
      end
      ADD: begin
        Busy = 1'b1;
        if (k == K_LAST) Sub = M;
        else             Add = M;
      end
      SHIFT: begin
        Shift = 1'b1;
        Busy  = 1'b1;
      end
      DONE:    Done = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = state;

endmodule
